// File: rtl/jtcop_rom_pkg.sv
// Shared types and address helpers for the jtcop ROM fetch slot.
package jtcop_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int LINE_WORDS = 2;

    // Line tag: one 32-bit line holds four bytes, two half-words or one word.
    function automatic logic [31:0] tag_of(input logic [31:0] addr, input logic [5:0] dw);
        case (dw)
            6'd8:    tag_of = addr >> 2;
            6'd16:   tag_of = addr >> 1;
            default: tag_of = addr;
        endcase
    endfunction

    function automatic logic [1:0] sel_of(input logic [31:0] addr, input logic [5:0] dw);
        case (dw)
            6'd8:    sel_of = addr[1:0];
            6'd16:   sel_of = {1'b0, addr[0]};
            default: sel_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtcop_rom_fetch_if.sv
// Client read port plus SDRAM bank port of one ROM fetch slot.
interface jtcop_rom_fetch_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic [AW-1:0] addr;
    logic          cs;
    logic          clr;
    logic          ok;
    logic [DW-1:0] dout;
    logic [21:0]   sdram_addr;
    logic          sdram_req;
    logic          sdram_ack;
    logic          data_dst;
    logic          data_rdy;
    logic [15:0]   data_read;

    modport master (
        output addr, cs, clr, sdram_ack, data_dst, data_rdy, data_read,
        input  ok, dout, sdram_addr, sdram_req
    );

    modport slave (
        input  addr, cs, clr, sdram_ack, data_dst, data_rdy, data_read,
        output ok, dout, sdram_addr, sdram_req
    );
endinterface

// File: rtl/jtcop_rom_line.sv
// One cache entry: tag, valid bit and a 32-bit line written per SDRAM word.
module jtcop_rom_line
    import jtcop_rom_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic                  i_valid,
    input  logic [LINE_WORDS-1:0] i_wstrb,
    input  logic [31:0]           i_wdata,
    input  logic [TW-1:0]         i_wtag,
    input  logic [TW-1:0]         i_ctag,
    output logic                  o_match,
    output logic                  o_valid,
    output logic [31:0]           o_data
);
    logic [TW-1:0] r_tag;
    logic          r_valid;
    logic [31:0]   r_data;

    // Entry storage; clr wins over a simultaneous refill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag   <= {TW{1'b0}};
            r_valid <= 1'b0;
            r_data  <= 32'd0;
        end else begin
            if (i_we) begin
                r_tag   <= i_wtag;
                r_valid <= i_valid;
            end
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (i_we && i_wstrb[w]) begin
                    r_data[16*w +: 16] <= i_wdata[16*w +: 16];
                end
            end
            if (i_clr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_match = r_valid && (r_tag == i_ctag);
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/jtcop_rom_fetch.sv
// ROM read slot: 2-entry line cache in front of one SDRAM bank port.
module jtcop_rom_fetch
    import jtcop_rom_pkg::*;
#(
    parameter int          AW     = 17,
    parameter int          DW     = 32,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    jtcop_rom_fetch_if.slave   bus
);
    localparam int TW    = (DW == 8) ? AW - 2 : (DW == 16) ? AW - 1 : AW;
    localparam int N_ENT = 2;

    if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_dw
        $error("jtcop_rom_fetch: DW must be 8, 16 or 32");
    end

    state_t        r_state, w_next;
    logic [TW-1:0] r_tag, w_tag;
    logic [21:0]   r_sdram_addr;
    logic [15:0]   r_w0, r_w1, w_fill_w0, w_fill_w1;
    logic          r_wcnt, r_clr_seen, r_lru;
    logic          w_start, w_fill, w_fill_valid, w_victim, w_hit_idx, w_ok;
    logic [N_ENT-1:0] w_match, w_valid;
    logic [31:0]   w_data [N_ENT];
    logic [31:0]   w_line;
    logic [DW-1:0] w_dout;

    assign w_tag = TW'(tag_of(32'(bus.addr), 6'(DW)));

    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_line
        jtcop_rom_line #(.TW(TW)) u_line (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (bus.clr),
            .i_we    (w_fill && (w_victim == 1'(gi))),
            .i_valid (w_fill_valid),
            .i_wstrb ({LINE_WORDS{1'b1}}),
            .i_wdata ({w_fill_w1, w_fill_w0}),
            .i_wtag  (r_tag),
            .i_ctag  (w_tag),
            .o_match (w_match[gi]),
            .o_valid (w_valid[gi]),
            .o_data  (w_data[gi])
        );
    end

    // clr masks ok in the very cycle it is raised, before the valid bits fall.
    assign w_ok         = bus.cs && (w_match != {N_ENT{1'b0}}) && !bus.clr;
    assign w_hit_idx    = w_match[0] ? 1'b0 : 1'b1;
    assign w_line       = w_match[0] ? w_data[0] : w_data[1];
    assign w_fill_valid = !r_clr_seen && !bus.clr;

    if (DW == 8) begin : g_dout8
        logic [1:0] w_sel;
        assign w_sel  = sel_of(32'(bus.addr), 6'd8);
        assign w_dout = w_line[{w_sel, 3'b000} +: 8];
    end else if (DW == 16) begin : g_dout16
        logic w_sel;
        assign w_sel  = 1'(sel_of(32'(bus.addr), 6'd16));
        assign w_dout = w_line[{w_sel, 4'b0000} +: 16];
    end else begin : g_dout32
        assign w_dout = w_line;
    end

    assign bus.ok         = w_ok;
    assign bus.dout       = w_ok ? w_dout : {DW{1'b0}};
    assign bus.sdram_req  = (r_state == REQ);
    assign bus.sdram_addr = r_sdram_addr;

    // Next state and one-cycle start/fill strobes.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_fill  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cs && !w_ok) begin
                    w_next  = REQ;
                    w_start = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    w_next = WAIT;
                end else begin
                    w_next = REQ;
                end
            end
            WAIT: begin
                if (bus.data_dst && bus.data_rdy) begin
                    w_next = IDLE;
                    w_fill = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The word arriving with data_rdy goes straight into the refilled entry.
    always_comb begin
        w_fill_w0 = r_w0;
        w_fill_w1 = r_w1;
        if (bus.data_dst && !r_wcnt) begin
            w_fill_w0 = bus.data_read;
        end else if (bus.data_dst) begin
            w_fill_w1 = bus.data_read;
        end else begin
            w_fill_w0 = r_w0;
            w_fill_w1 = r_w1;
        end
    end

    // Refill goes to an invalid entry first, otherwise to the LRU one.
    always_comb begin
        w_victim = r_lru;
        if (!w_valid[0]) begin
            w_victim = 1'b0;
        end else if (!w_valid[1]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request registers, burst word buffer and LRU pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag        <= {TW{1'b0}};
            r_sdram_addr <= OFFSET;
            r_w0         <= 16'd0;
            r_w1         <= 16'd0;
            r_wcnt       <= 1'b0;
            r_clr_seen   <= 1'b0;
            r_lru        <= 1'b0;
        end else begin
            if (w_start) begin
                r_tag        <= w_tag;
                r_sdram_addr <= OFFSET + 22'({w_tag, 1'b0});
                r_wcnt       <= 1'b0;
                r_clr_seen   <= 1'b0;
            end
            if (r_state == WAIT && bus.data_dst) begin
                if (!r_wcnt) r_w0 <= bus.data_read;
                else         r_w1 <= bus.data_read;
                r_wcnt <= 1'b1;
            end
            if ((r_state == REQ || r_state == WAIT) && bus.clr) begin
                r_clr_seen <= 1'b1;
            end
            if (w_fill)    r_lru <= ~w_victim;
            else if (w_ok) r_lru <= ~w_hit_idx;
        end
    end
endmodule

// File: tb/tb_jtcop_rom_fetch.sv
// Bench for jtcop_rom_fetch: DW=16/8/32 instances share one SDRAM data path.
module tb_jtcop_rom_fetch;
    localparam logic [21:0] OFF16 = 22'h10_0000;
    localparam logic [21:0] OFF8  = 22'h00_0000;
    localparam logic [21:0] OFF32 = 22'h3F_FFFE;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ack = 1'b0, dst = 1'b0, rdy = 1'b0;
    logic [15:0] rdata = 16'd0;
    int          n_chk = 0, n_fail = 0;
    int          q[$];          // model: valid tags, most recently used first

    typedef struct {
        logic [16:0] addr;
        logic        cs;
        logic        exp_ok;
        logic [7:0]  exp_dout;
    } vec_t;
    vec_t tv[6];

    jtcop_rom_fetch_if #(.AW(17), .DW(16)) if16();
    jtcop_rom_fetch_if #(.AW(17), .DW(8))  if8();
    jtcop_rom_fetch_if #(.AW(17), .DW(32)) if32();

    assign if16.sdram_ack = ack; assign if16.data_dst = dst; assign if16.data_rdy = rdy; assign if16.data_read = rdata;
    assign if8.sdram_ack  = ack; assign if8.data_dst  = dst; assign if8.data_rdy  = rdy; assign if8.data_read  = rdata;
    assign if32.sdram_ack = ack; assign if32.data_dst = dst; assign if32.data_rdy = rdy; assign if32.data_read = rdata;

    jtcop_rom_fetch #(.AW(17), .DW(16), .OFFSET(OFF16)) u16 (.i_clk(clk), .i_rst(rst), .bus(if16));
    jtcop_rom_fetch #(.AW(17), .DW(8),  .OFFSET(OFF8))  u8  (.i_clk(clk), .i_rst(rst), .bus(if8));
    jtcop_rom_fetch #(.AW(17), .DW(32), .OFFSET(OFF32)) u32 (.i_clk(clk), .i_rst(rst), .bus(if32));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // SDRAM content as a fixed function of the word address.
    function automatic logic [15:0] mem(input logic [21:0] wa);
        return wa[15:0] ^ {wa[7:0], wa[15:8]} ^ {10'd0, wa[21:16]} ^ 16'hC3A5;
    endfunction

    function automatic bit m_has(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_touch(input int t);
        int k[$];
        k = q.find_index with (item == t);
        if (k.size() > 0) q.delete(k[0]);
        q.push_front(t);
        if (q.size() > 2) void'(q.pop_back());
    endfunction

    function automatic logic req_of(input int w);
        case (w)
            8:       return if8.sdram_req;
            32:      return if32.sdram_req;
            default: return if16.sdram_req;
        endcase
    endfunction

    // Called one step after a falling edge with sdram_req already high.
    task automatic burst(input int w, input int dly, input logic [15:0] w0, input logic [15:0] w1);
        repeat (dly) begin
            @(negedge clk); #1;
            chk("req_hold", 32'(req_of(w)), 32'd1);
        end
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0; #1;
        chk("req_drop", 32'(req_of(w)), 32'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk); dst = 1'b1; rdata = w0;
        @(negedge clk); dst = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk); dst = 1'b1; rdy = 1'b1; rdata = w1;
        @(negedge clk); dst = 1'b0; rdy = 1'b0;
    endtask

    task automatic access16(input logic [16:0] a, output bit was_hit);
        int          t;
        logic [21:0] wa;
        logic [15:0] exp;
        t   = int'(a >> 1);
        wa  = OFF16 + 22'(2 * t);
        exp = mem(wa + 22'(a[0]));
        @(negedge clk); if16.addr = a; if16.cs = 1'b1; #1;
        was_hit = if16.ok;
        chk("acc_ok", 32'(if16.ok), 32'(m_has(t)));
        if (m_has(t)) begin
            chk("acc_hit_dout", 32'(if16.dout), 32'(exp));
        end else begin
            @(negedge clk); #1;
            chk("acc_req", 32'(if16.sdram_req), 32'd1);
            chk("acc_sdram_addr", 32'(if16.sdram_addr), 32'(wa));
            burst(16, $urandom_range(0, 3), mem(wa), mem(wa + 22'd1));
            #1;
            chk("acc_fill_ok", 32'(if16.ok), 32'd1);
            chk("acc_fill_dout", 32'(if16.dout), 32'(exp));
        end
        m_touch(t);
    endtask

    initial begin
        bit          h;
        logic [21:0] wa;
        int          t;
        tv[0] = '{17'd0, 1'b1, 1'b1, 8'hAA};
        tv[1] = '{17'd1, 1'b1, 1'b1, 8'hBB};
        tv[2] = '{17'd2, 1'b1, 1'b1, 8'hCC};
        tv[3] = '{17'd3, 1'b1, 1'b1, 8'hDD};
        tv[4] = '{17'd2, 1'b0, 1'b0, 8'h00};
        tv[5] = '{17'd1, 1'b1, 1'b1, 8'hBB};
        if16.addr = 17'd0; if16.cs = 1'b0; if16.clr = 1'b0;
        if8.addr  = 17'd0; if8.cs  = 1'b0; if8.clr  = 1'b0;
        if32.addr = 17'd0; if32.cs = 1'b0; if32.clr = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_req16", 32'(if16.sdram_req), 32'd0);
        chk("rst_ok16", 32'(if16.ok), 32'd0);
        chk("rst_dout16", 32'(if16.dout), 32'd0);
        chk("rst_addr16", 32'(if16.sdram_addr), 32'(OFF16));
        chk("rst_req8", 32'(if8.sdram_req), 32'd0);
        chk("rst_addr8", 32'(if8.sdram_addr), 32'(OFF8));
        chk("rst_req32", 32'(if32.sdram_req), 32'd0);
        chk("rst_dout32", if32.dout, 32'd0);
        chk("rst_addr32", 32'(if32.sdram_addr), 32'(OFF32));

        // Miss then hit, DW=16
        @(negedge clk); if16.addr = 17'h0_0003; if16.cs = 1'b1; #1;
        chk("mh_miss_ok", 32'(if16.ok), 32'd0);
        @(negedge clk); #1;
        chk("mh_req", 32'(if16.sdram_req), 32'd1);
        chk("mh_sdram_addr", 32'(if16.sdram_addr), 32'h10_0002);
        burst(16, 1, 16'h1111, 16'h2222); #1;
        chk("mh_ok", 32'(if16.ok), 32'd1);
        chk("mh_dout3", 32'(if16.dout), 32'h2222);
        @(negedge clk); if16.addr = 17'h0_0002; #1;
        chk("mh_ok2", 32'(if16.ok), 32'd1);
        chk("mh_dout2", 32'(if16.dout), 32'h1111);
        @(negedge clk); #1;
        chk("mh_no_req", 32'(if16.sdram_req), 32'd0);
        @(negedge clk); if16.clr = 1'b1; #1;
        chk("clr_ok_drop", 32'(if16.ok), 32'd0);
        #1 if16.cs = 1'b0;
        @(negedge clk); if16.clr = 1'b0;
        q.delete();

        // Two entries and LRU replacement
        access16(17'd10, h);
        access16(17'd18, h);
        access16(17'd10, h); chk("lru_t5_hit", 32'(h), 32'd1);
        access16(17'd24, h); chk("lru_t12_miss", 32'(h), 32'd0);
        access16(17'd10, h); chk("lru_t5_kept", 32'(h), 32'd1);
        access16(17'd18, h); chk("lru_t9_gone", 32'(h), 32'd0);

        // clr during WAIT after the first word
        wa = OFF16 + 22'd80;
        @(negedge clk); if16.addr = 17'd80; if16.cs = 1'b1;
        @(negedge clk); #1;
        chk("cb_req", 32'(if16.sdram_req), 32'd1);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0; dst = 1'b1; rdata = mem(wa);
        @(negedge clk); dst = 1'b0; if16.clr = 1'b1;
        @(negedge clk); if16.clr = 1'b0; dst = 1'b1; rdy = 1'b1; rdata = mem(wa + 22'd1);
        @(negedge clk); dst = 1'b0; rdy = 1'b0; #1;
        q.delete();
        chk("cb_ok_low", 32'(if16.ok), 32'd0);
        @(negedge clk); #1;
        chk("cb_rereq", 32'(if16.sdram_req), 32'd1);
        chk("cb_rereq_addr", 32'(if16.sdram_addr), 32'(wa));
        burst(16, 0, mem(wa), mem(wa + 22'd1)); #1;
        chk("cb_ok", 32'(if16.ok), 32'd1);
        chk("cb_dout", 32'(if16.dout), 32'(mem(wa)));
        m_touch(40);

        // Reset while the request is pending
        wa = OFF16 + 22'h100;
        @(negedge clk); if16.addr = 17'h100; #1;
        chk("rm_miss", 32'(if16.ok), 32'd0);
        @(negedge clk); #1;
        chk("rm_req", 32'(if16.sdram_req), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; if16.cs = 1'b0; #1;
        q.delete();
        chk("rm_req_low", 32'(if16.sdram_req), 32'd0);
        chk("rm_ok_low", 32'(if16.ok), 32'd0);
        chk("rm_addr", 32'(if16.sdram_addr), 32'(OFF16));
        @(negedge clk); dst = 1'b1; rdy = 1'b1; rdata = 16'hDEAD;
        @(negedge clk); dst = 1'b0; rdy = 1'b0; if16.cs = 1'b1; #1;
        chk("rm_late_ignored", 32'(if16.ok), 32'd0);
        @(negedge clk); #1;
        chk("rm_clean_req", 32'(if16.sdram_req), 32'd1);
        chk("rm_clean_addr", 32'(if16.sdram_addr), 32'(wa));
        burst(16, 0, mem(wa), mem(wa + 22'd1)); #1;
        chk("rm_ok", 32'(if16.ok), 32'd1);
        chk("rm_dout", 32'(if16.dout), 32'(mem(wa)));
        m_touch(128);

        // Byte selection, DW=8, table driven
        @(negedge clk); if8.addr = 17'd0; if8.cs = 1'b1;
        @(negedge clk); #1;
        chk("b8_req", 32'(if8.sdram_req), 32'd1);
        chk("b8_addr", 32'(if8.sdram_addr), 32'd0);
        burst(8, 0, 16'hBBAA, 16'hDDCC);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); if8.addr = tv[i].addr; if8.cs = tv[i].cs; #1;
            chk($sformatf("b8_ok[%0d]", i), 32'(if8.ok), 32'(tv[i].exp_ok));
            if (tv[i].exp_ok) chk($sformatf("b8_dout[%0d]", i), 32'(if8.dout), 32'(tv[i].exp_dout));
            chk($sformatf("b8_no_req[%0d]", i), 32'(if8.sdram_req), 32'd0);
        end
        if8.cs = 1'b0;

        // DW=32 with SDRAM address wrap
        @(negedge clk); if32.addr = 17'd1; if32.cs = 1'b1; #1;
        chk("w32_miss", 32'(if32.ok), 32'd0);
        @(negedge clk); #1;
        chk("w32_req", 32'(if32.sdram_req), 32'd1);
        chk("w32_addr", 32'(if32.sdram_addr), 32'd0);
        burst(32, 2, 16'h1234, 16'hABCD); #1;
        chk("w32_ok", 32'(if32.ok), 32'd1);
        chk("w32_dout", if32.dout, 32'hABCD_1234);
        if32.cs = 1'b0;

        // Randomised accesses against the LRU cache model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); if16.cs = 1'b0; if16.clr = 1'b1;
                @(negedge clk); if16.clr = 1'b0;
                q.delete();
            end else begin
                t = $urandom_range(0, 9);
                if (t >= 8) t = $urandom_range(0, 65535);
                access16({16'(t), 1'($urandom)}, h);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
